// File: rtl/bridge_pkg.sv
// Shared constants, FSM state type and ASCII hex helper for the bridge response path.
package bridge_pkg;

  localparam logic [7:0] PREAMBLE = 8'h4D;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam int         MSG_LEN  = 7;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } bridge_tx_state_t;

  function automatic logic [7:0] to_hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return 8'h30 + {4'h0, nibble};
    end
    return 8'h37 + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/response_fifo.sv
// Synchronous FIFO for queued read words; a push is accepted while full when a pop happens the same cycle.
module response_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bridge_tx.sv
// Serializes each bus read into "M" + 4 hex digits + CR LF over a valid/ready byte stream.
// Optional read queue behind the active word is enabled by defining BRIDGE_TX_FIFO_EN.
module bridge_tx
  import bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic [15:0] rdata_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        overflow_o
);

  // Byte stream: data_o is transferred on any cycle with valid_o && ready_i;
  // while valid_o is high and ready_i low, data_o and valid_o hold their values.

  localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);

  bridge_tx_state_t state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        overflow_q, overflow_d;

  logic        capture, xfer, last_xfer, free_slot;
  logic        load, drop;
  logic [15:0] load_word;
  logic        unused_ok;

  assign unused_ok = ^{addr_i, wdata_i, (FIFO_DEPTH > 0)};

  assign capture   = valid_i && !rw_i;
  assign xfer      = valid_q && ready_i;
  assign last_xfer = xfer && (idx_q == LAST_IDX);
  assign free_slot = (state_q == IDLE) || last_xfer;

  function automatic logic [7:0] msg_byte(input logic [15:0] w, input logic [2:0] idx);
    case (idx)
      3'd0:    return PREAMBLE;
      3'd1:    return to_hex_ascii(w[15:12]);
      3'd2:    return to_hex_ascii(w[11:8]);
      3'd3:    return to_hex_ascii(w[7:4]);
      3'd4:    return to_hex_ascii(w[3:0]);
      3'd5:    return CR;
      default: return LF;
    endcase
  endfunction

`ifdef BRIDGE_TX_FIFO_EN
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [15:0] fifo_head;

  // Queue head wins over a same-cycle arrival, which then goes behind it.
  always_comb begin
    fifo_pop  = free_slot && !fifo_empty;
    fifo_push = capture && (free_slot ? !fifo_empty : !fifo_full);
    drop      = capture && !free_slot && fifo_full;
    load      = free_slot && (!fifo_empty || capture);
    load_word = fifo_empty ? rdata_i : fifo_head;
  end

  response_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (rdata_i),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
`else
  always_comb begin
    load      = free_slot && capture;
    drop      = capture && !free_slot;
    load_word = rdata_i;
  end
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    if (load) begin
      state_d = SEND;
      word_d  = load_word;
      idx_d   = '0;
    end else if (last_xfer) begin
      state_d = IDLE;
    end else if (xfer) begin
      idx_d = idx_q + 1'b1;
    end
    overflow_d = overflow_q || drop;
    valid_d    = (state_d == SEND);
    data_d     = valid_d ? msg_byte(word_d, idx_d) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign overflow_o = overflow_q;

endmodule

// File: doc/bridge_tx.md
# bridge_tx

Response serializer that sits directly downstream of `logic_analyzer` at the end of the bus chain. It consumes the bus output port and turns every completed read into a 7-byte ASCII response for the UART transmitter. The byte output uses a valid/ready handshake. Writes pass silently and produce no response.

## Interface
Parameters:
- FIFO_DEPTH, 4, number of queued read responses, power of two ≥ 2; used only when `BRIDGE_TX_FIFO_EN` is defined.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- addr_i  input  16  bus address (ignored, kept for bus uniformity).
- wdata_i  input  16  bus write data (ignored).
- rdata_i  input  16  bus read data to be reported.
- rw_i  input  1  1 = write, 0 = read.
- valid_i  input  1  bus transaction present this cycle.
- data_o  output  8  byte to UART transmitter.
- valid_o  output  1  data_o holds a valid byte.
- ready_i  input  1  transmitter accepts data_o this cycle.
- overflow_o  output  1  sticky flag: at least one read response was dropped.

## Operation
- Response captured when `valid_i && !rw_i`. Writes (`rw_i=1`) and idle cycles are ignored.
- Message format is 7 bytes: `0x4D` ('M'), then four hex digits of rdata_i (MSB nibble first, uppercase ASCII), then `0x0D`, then `0x0A`.
- Hex encoding:
  - nibble 0–9 → 0x30+n
  - nibble A–F → 0x41+(n−10)
- Active word register holds the message being sent. Byte index counter runs 0..6.
- FSM:
  - IDLE: valid_o=0. A captured response, or a non-empty queue, loads the active register, sets index 0 and moves to SEND.
  - SEND: valid_o=1. data_o is selected by the index.
  - Transfer occurs on `valid_o && ready_i`, which increments the index.
  - On transfer of index 6: if a response is pending, load it, set index 0 and stay in SEND; otherwise return to IDLE.
- Pending-source priority when the active register frees: queue head first, then a response arriving the same cycle. If the queue is non-empty, the arriving response is enqueued.
- A response arriving while the active register is busy goes to the queue. If it cannot be queued, it is dropped and overflow_o is set.
- overflow_o is cleared only by reset.
- Reset values: data_o=0x00, valid_o=0, overflow_o=0, FSM=IDLE, index=0, queue empty.
- Reset asserted mid-message discards the active word and the queue. valid_o is low the cycle after rst_n is sampled low.

## Timing
- Latency: read on valid_i in cycle N while IDLE with empty queue → valid_o=1, data_o=0x4D in cycle N+1.
- data_o and valid_o are registered. While `valid_o && !ready_i`, both are held stable.
- With ready_i held high, one byte is transferred per cycle: 7 cycles per message.
- Back-to-back messages have no bubble: cycle after the 0x0A transfer presents the next 0x4D when a response is pending.
- Simultaneous read arrival and 0x0A transfer: the arrival is accepted, never dropped, in both configurations.
- Queue write and read in the same cycle while full is allowed; the count is unchanged.

## Configuration
- `BRIDGE_TX_FIFO_EN` defined: a FIFO_DEPTH-entry 16-bit queue sits behind the active register. A drop occurs only when the active register is busy and the queue is full.
- Undefined: no queue. A read arriving while SEND is busy is dropped and sets overflow_o, except in the same-cycle-as-0x0A case, where it loads directly into the active register.

## Structure
- Shared package `bridge_pkg`:
  - constants `PREAMBLE=8'h4D`, `CR=8'h0D`, `LF=8'h0A`, `MSG_LEN=7`
  - FSM enum `bridge_tx_state_t` {IDLE, SEND}
  - function `to_hex_ascii(nibble)`
- One sub-module: `response_fifo` (synchronous FIFO with width and depth parameters, plus full/empty). It is instantiated only under `BRIDGE_TX_FIFO_EN`.

## Test plan
- Single read, rdata_i=0xBEEF, ready_i=1 → bytes 4D 42 45 45 46 0D 0A on consecutive cycles starting N+1; then valid_o=0.
- Write, rw_i=1, rdata_i=0x1234 → valid_o stays 0 for 20 cycles; overflow_o=0.
- Read 0x00A5 with ready_i low for 5 cycles at index 2 → data_o=0x30 and valid_o=1 held throughout; sequence then completes as 4D 30 30 41 35 0D 0A.
- Three reads in consecutive cycles (0x0001, 0x0002, 0x0003), ready_i=1:
  - with macro → 21 contiguous bytes, no bubble, overflow_o=0
  - without macro → only the 0x0001 message, overflow_o=1
- Read 0xFFFF arriving in the same cycle as the 0x0A transfer, without macro → next cycle 0x4D, message 46 46 46 46 follows, overflow_o=0.
- rst_n low at index 3 with a queued entry → valid_o=0 next cycle, no further bytes after release, overflow_o=0.
